// File: rtl/sram_port_sequencer_if.sv
// Requester-side bundle for sram_port_sequencer: instruction-fetch port A
// (read-only) and data port B (read/write), each with a one-cycle done pulse.
interface sram_port_sequencer_if #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 32
);
  logic              a_req;
  logic [ADDR_W-1:0] a_addr;
  logic              a_done;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_done;
  logic [DATA_W-1:0] b_rdata;

  modport master (
    output a_req, a_addr,
    input  a_done, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_done, b_rdata
  );

  modport slave (
    input  a_req, a_addr,
    output a_done, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_done, b_rdata
  );
endinterface

// File: rtl/sram_port_sequencer.sv
// Two-port round-robin sequencer for the 3-phase-clocked 32-bit SRAM macro.
// Every pin toward the macro and the requesters comes straight from a flop.
module sram_port_sequencer #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 32
) (
  input  logic                Clock1,
  input  logic                RST,
  sram_port_sequencer_if.slave req_if,
  output logic                MemClk1,
  output logic                MemClk2,
  output logic                MemClk3,
  output logic [ADDR_W-1:0]   AdxBus,
  output logic                RNW,
  output logic                OE,
  inout  wire  [DATA_W-1:0]   DataBus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_DATA  = 3'd2,
    S_READ  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic                mc1_q, mc1_d;
  logic                mc2_q, mc2_d;
  logic                mc3_q, mc3_d;
  logic                oe_q, oe_d;
  logic                rnw_q, rnw_d;
  logic                drv_q, drv_d;
  logic [ADDR_W-1:0]   adx_q, adx_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                port_b_q, port_b_d;
  logic                we_q, we_d;
  logic                last_b_q, last_b_d;
  logic                a_done_q, a_done_d;
  logic                b_done_q, b_done_d;
  logic [DATA_W-1:0]   a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0]   b_rdata_q, b_rdata_d;
  logic                in_rst_q;
  logic                grant_a, grant_b;

  // Round robin: on a tie the port not granted last wins.
  always_comb begin
    grant_b = req_if.b_req & (~req_if.a_req | ~last_b_q);
    grant_a = req_if.a_req & ~grant_b;
  end

  // Next state plus the value each pin takes in that next state.
  always_comb begin
    state_d   = state_q;
    mc1_d     = 1'b0;
    mc2_d     = 1'b0;
    mc3_d     = 1'b0;
    oe_d      = 1'b1;
    rnw_d     = rnw_q;
    drv_d     = 1'b0;
    adx_d     = adx_q;
    wdata_d   = wdata_q;
    port_b_d  = port_b_q;
    we_d      = we_q;
    last_b_d  = last_b_q;
    a_done_d  = 1'b0;
    b_done_d  = 1'b0;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (grant_a || grant_b) begin
          port_b_d = grant_b;
          last_b_d = grant_b;
          we_d     = grant_b & req_if.b_we;
          adx_d    = grant_b ? req_if.b_addr : req_if.a_addr;
          wdata_d  = req_if.b_wdata;
          rnw_d    = ~(grant_b & req_if.b_we);
          mc1_d    = 1'b1;
          drv_d    = grant_b & req_if.b_we;
          state_d  = S_ADDR;
        end
      end
      S_ADDR: begin
        mc2_d   = 1'b1;
        drv_d   = we_q;
        state_d = S_DATA;
      end
      S_DATA: begin
        if (we_q) begin
          mc3_d   = 1'b1;
          drv_d   = 1'b1;
          state_d = S_WRITE;
        end else begin
          oe_d    = 1'b0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (port_b_q) b_rdata_d = DataBus;
        else          a_rdata_d = DataBus;
        a_done_d = ~port_b_q;
        b_done_d = port_b_q;
        rnw_d    = 1'b1;
        state_d  = S_DONE;
      end
      S_WRITE: begin
        a_done_d = ~port_b_q;
        b_done_d = port_b_q;
        rnw_d    = 1'b1;
        state_d  = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        rnw_d   = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // Reset holds the bus idle and toggles MemClk3 so the macro reloads its init image.
  always_ff @(posedge Clock1) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      mc1_q     <= 1'b0;
      mc2_q     <= 1'b0;
      mc3_q     <= in_rst_q ? ~mc3_q : 1'b0;
      in_rst_q  <= 1'b1;
      oe_q      <= 1'b1;
      rnw_q     <= 1'b1;
      drv_q     <= 1'b0;
      adx_q     <= '0;
      wdata_q   <= '0;
      port_b_q  <= 1'b0;
      we_q      <= 1'b0;
      last_b_q  <= 1'b1;
      a_done_q  <= 1'b0;
      b_done_q  <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      mc1_q     <= mc1_d;
      mc2_q     <= mc2_d;
      mc3_q     <= mc3_d;
      in_rst_q  <= 1'b0;
      oe_q      <= oe_d;
      rnw_q     <= rnw_d;
      drv_q     <= drv_d;
      adx_q     <= adx_d;
      wdata_q   <= wdata_d;
      port_b_q  <= port_b_d;
      we_q      <= we_d;
      last_b_q  <= last_b_d;
      a_done_q  <= a_done_d;
      b_done_q  <= b_done_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  assign MemClk1 = mc1_q;
  assign MemClk2 = mc2_q;
  assign MemClk3 = mc3_q;
  assign AdxBus  = adx_q;
  assign RNW     = rnw_q;
  assign OE      = oe_q;
  assign DataBus = drv_q ? wdata_q : {DATA_W{1'bz}};

  assign req_if.a_done  = a_done_q;
  assign req_if.a_rdata = a_rdata_q;
  assign req_if.b_done  = b_done_q;
  assign req_if.b_rdata = b_rdata_q;

endmodule

// File: doc/sram_port_sequencer.md
Name: sram_port_sequencer

Overview:
- Two-requester controller for the 32-bit SRAM macro (11-bit AdxBus, tristate DataBus, OE, RNW, three phase clocks, RST).
- Arbitrates between an instruction-fetch port A (read-only) and a data port B (read/write).
- Generates the macro's three phase strobes as registered pulses from Clock1, and drives AdxBus, RNW, OE and DataBus.
- Returns read data with a one-cycle done pulse. During reset it toggles the Clock3 strobe so the macro's reset-time contents are loaded.

Parameters:
ADDR_W, 11, address width on AdxBus and requester ports
DATA_W, 32, data width

Ports:
Clock1  input  1  system clock; all logic is posedge Clock1
RST  input  1  reset, synchronous, active-low
a_req  input  1  port A read request, level
a_addr  input  ADDR_W  port A address
a_done  output  1  one-cycle pulse, a_rdata valid
a_rdata  output  DATA_W  port A read data, held until next A read completes
b_req  input  1  port B request, level
b_we  input  1  1 = write, 0 = read
b_addr  input  ADDR_W  port B address
b_wdata  input  DATA_W  port B write data
b_done  output  1  one-cycle pulse, transaction complete
b_rdata  output  DATA_W  port B read data, held until next B read completes
MemClk1  output  1  to SRAM Clock1 (MAR latch)
MemClk2  output  1  to SRAM Clock2 (MDR latch)
MemClk3  output  1  to SRAM Clock3 (write / reset init)
AdxBus  output  ADDR_W  SRAM address
RNW  output  1  SRAM read/not-write
OE  output  1  SRAM output enable, active-low drive
DataBus  inout  DATA_W  SRAM data bus

Behaviour:
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Reset (RST=0 at a Clock1 edge):
  - State goes to IDLE.
  - MemClk1=MemClk2=0; OE=1; RNW=1; AdxBus=0; DataBus released (z).
  - a_done=b_done=0; a_rdata=b_rdata=0.
  - Last-grant pointer is set to B, so A wins the first tie.
  - MemClk3 toggles on every edge while RST=0, starting from 0. This gives a posedge every 2 cycles, which loads the macro's init values.
  - Reset mid-transaction aborts the transaction without a done pulse. The memory write is suppressed because RNW is forced to 1.
- FSM states: IDLE, ADDR, DATA, READ, WRITE, DONE. Each state lasts exactly one cycle except IDLE.
- IDLE:
  - If neither request is asserted, stay in IDLE.
  - If only one request is asserted, grant it.
  - If both are asserted, grant the port not granted last (round-robin), then update the pointer.
  - On grant: latch port, address, op (A is always read) and wdata. Set AdxBus=addr and RNW=~we. Go to ADDR.
- ADDR: MemClk1=1. For a write, drive DataBus=wdata (OE stays 1). Go to DATA.
- DATA: MemClk1=0, MemClk2=1. A write keeps driving DataBus. Go to READ if op is read, else WRITE.
- READ: MemClk2=0, OE=0, controller releases DataBus. Go to DONE, sampling DataBus into the granted port's rdata at the exiting edge.
- WRITE: MemClk2=0, MemClk3=1 with RNW=0, DataBus still driven. Go to DONE.
- DONE:
  - MemClk3=0, OE=1, RNW=1, DataBus released.
  - The granted port's done=1 for exactly this cycle.
  - Go to IDLE.
- Latency and throughput:
  - A request sampled at edge E0 in IDLE asserts done in the cycle after E3.
  - Read data is valid in that same cycle.
  - Peak throughput is one transaction per 5 cycles, because IDLE takes one cycle per transaction.
- The controller never drives DataBus while OE=0. Exactly one of {controller drive, OE=0} is active, or neither.
- Request rules:
  - req, addr, we and wdata are sampled only in IDLE. Changes or deassertion after grant are ignored, and the transaction completes and pulses done.
  - A req still high in IDLE after done starts a new transaction, subject to arbitration.
- Starvation-free: under continuous requests from both ports, grants alternate A, B, A, B.
- Address is passed through unmodified. The macro uses only bits [9:0]; bit 10 is don't-care to the controller.

Test Plan:
- Release reset after 6 cycles with RST=0 -> MemClk3 shows 3 posedges, OE=1, RNW=1, DataBus=z. Then A read of addr 1 -> a_done 4 cycles after grant, a_rdata=32'h0000_0008 (high half 0).
- B write addr 5 data 32'hDEAD_BEEF, then B read addr 5 -> RNW=0 only during ADDR..WRITE; MemClk3 pulses once. Read returns 32'hDEAD_BEEF on b_done.
- a_req and b_req both held high for 4 transactions from reset -> grant order A, B, A, B. Each done pulse is exactly 1 cycle, and the other port's done stays 0.
- b_req dropped in DATA state (b_we=1, addr 7, data 32'h1234_5678) -> write still completes, b_done pulses, and a later read of addr 7 returns 32'h1234_5678.
- RST asserted during WRITE state -> no b_done, RNW=1 and OE=1 at the next edge. The target address is not overwritten; a read after reset shows the init/prior value.
- Bus contention check across all tests: assert the controller never drives DataBus while OE=0, and that MemClk1/2/3 are never high simultaneously outside reset.
